// File: rtl/acc_unit.sv
// acc_unit: 8-bit accumulator / operand-register stage around add8b.
// Subtraction runs as two adder passes: negate B, then add to A.
module add8b (
    input  logic [7:0] x,
    input  logic [7:0] y,
    output logic [7:0] s,
    output logic       c_out
);
    logic [8:0] cy;

    assign cy[0] = 1'b0;

    for (genvar i = 0; i < 8; i++) begin : g_fa
        assign s[i]    = x[i] ^ y[i] ^ cy[i];
        assign cy[i+1] = (x[i] & y[i]) | (cy[i] & (x[i] ^ y[i]));
    end

    assign c_out = cy[8];
endmodule

module acc_unit #(
    parameter logic [7:0] ACC_RST = 8'h00,
    parameter logic [7:0] B_RST   = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic [2:0] op,
    input  logic [7:0] din,
    output logic [7:0] acc,
    output logic [7:0] b_out,
    output logic       carry,
    output logic       zero,
    output logic       done
);
    typedef enum logic [1:0] {
        IDLE,
        ADD1,
        NEG,
        SUB2
    } state_t;

    state_t     state;
    logic [7:0] t;
    logic       c1;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] s;
    logic       c_out;
    logic       is_lda;
    logic       is_ldb;
    logic       is_add;
    logic       is_sub;
    logic       is_clr;

    add8b u_add (
        .x     (x),
        .y     (y),
        .s     (s),
        .c_out (c_out)
    );

    assign op_ready = (state == IDLE);

    assign is_lda = (op == 3'b001);
    assign is_ldb = (op == 3'b010);
    assign is_add = (op == 3'b011);
    assign is_sub = (op == 3'b100);
    assign is_clr = (op == 3'b101);

    // Two's-complement negate of B on the NEG pass, A + (-B) on SUB2.
    always_comb begin
        x = acc;
        y = b_out;
        case (state)
            NEG: begin
                x = ~b_out;
                y = 8'h01;
            end
            SUB2: y = t;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= ACC_RST;
            b_out <= B_RST;
            carry <= 1'b0;
            zero  <= (ACC_RST == 8'h00);
            done  <= 1'b0;
            t     <= 8'h00;
            c1    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        unique case (1'b1)
                            is_lda: begin
                                acc  <= din;
                                zero <= (din == 8'h00);
                                done <= 1'b1;
                            end
                            is_ldb: begin
                                b_out <= din;
                                done  <= 1'b1;
                            end
                            is_clr: begin
                                acc   <= 8'h00;
                                carry <= 1'b0;
                                zero  <= 1'b1;
                                done  <= 1'b1;
                            end
                            is_add: state <= ADD1;
                            is_sub: state <= NEG;
                            default: done <= 1'b1;
                        endcase
                    end
                end
                ADD1: begin
                    acc   <= s;
                    carry <= c_out;
                    zero  <= (s == 8'h00);
                    done  <= 1'b1;
                    state <= IDLE;
                end
                NEG: begin
                    t     <= s;
                    c1    <= c_out;
                    state <= SUB2;
                end
                SUB2: begin
                    // c1 covers B==0, where -B wraps to 0 with a carry.
                    acc   <= s;
                    carry <= c_out | c1;
                    zero  <= (s == 8'h00);
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_acc_unit.sv
// tb_acc_unit: directed self-checking bench for acc_unit.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_acc_unit;
    logic       clk;
    logic       rst_n;
    logic       op_valid;
    logic       op_ready;
    logic [2:0] op;
    logic [7:0] din;
    logic [7:0] acc;
    logic [7:0] b_out;
    logic       carry;
    logic       zero;
    logic       done;

    int vectors;
    int miscompares;

    localparam logic [2:0] NOP = 3'b000;
    localparam logic [2:0] LDA = 3'b001;
    localparam logic [2:0] LDB = 3'b010;
    localparam logic [2:0] ADD = 3'b011;
    localparam logic [2:0] SUB = 3'b100;
    localparam logic [2:0] CLR = 3'b101;
    localparam logic [2:0] RSV = 3'b111;

    acc_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op       (op),
        .din      (din),
        .acc      (acc),
        .b_out    (b_out),
        .carry    (carry),
        .zero     (zero),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one op for exactly one accept edge, then returns to NOP.
    task automatic issue(input logic [2:0] o, input logic [7:0] d);
        int n;
        n = 0;
        while (op_ready !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        vectors++;
        if (op_ready !== 1'b1) begin
            $display("FAIL ready_timeout op_ready=%b required 1", op_ready);
            miscompares++;
        end
        op_valid = 1'b1;
        op       = o;
        din      = d;
        tick();
        op_valid = 1'b0;
        op       = NOP;
        din      = 8'h00;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        vectors++;
        if (acc !== 8'h00) begin
            $display("FAIL rst_acc got %h required 00", acc);
            miscompares++;
        end
        vectors++;
        if (b_out !== 8'h00) begin
            $display("FAIL rst_b got %h required 00", b_out);
            miscompares++;
        end
        vectors++;
        if ({carry, zero, done, op_ready} !== 4'b0101) begin
            $display("FAIL rst_flags c/z/d/r got %b required 0101",
                     {carry, zero, done, op_ready});
            miscompares++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_add();
        issue(LDA, 8'h0F);
        vectors++;
        if ({done, acc, zero} !== {1'b1, 8'h0F, 1'b0}) begin
            $display("FAIL lda_0f d/acc/z got %b %h %b required 1 0f 0",
                     done, acc, zero);
            miscompares++;
        end
        issue(LDB, 8'h03);
        vectors++;
        if ({done, b_out} !== {1'b1, 8'h03}) begin
            $display("FAIL ldb_03 d/b got %b %h required 1 03", done, b_out);
            miscompares++;
        end
        issue(ADD, 8'h00);
        vectors++;
        if ({op_ready, done, acc} !== {1'b0, 1'b0, 8'h0F}) begin
            $display("FAIL add_busy r/d/acc got %b %b %h required 0 0 0f",
                     op_ready, done, acc);
            miscompares++;
        end
        tick();
        vectors++;
        if ({op_ready, done, acc, carry, zero} !==
            {1'b1, 1'b1, 8'h12, 1'b0, 1'b0}) begin
            $display("FAIL add_12 r/d/acc/c/z got %b %b %h %b %b required 1 1 12 0 0",
                     op_ready, done, acc, carry, zero);
            miscompares++;
        end
        tick();
        vectors++;
        if (done !== 1'b0) begin
            $display("FAIL add_done_pulse got %b required 0", done);
            miscompares++;
        end

        issue(LDA, 8'hF0);
        issue(LDB, 8'h20);
        issue(ADD, 8'h00);
        tick();
        vectors++;
        if ({done, acc, carry, zero} !== {1'b1, 8'h10, 1'b1, 1'b0}) begin
            $display("FAIL add_ovf d/acc/c/z got %b %h %b %b required 1 10 1 0",
                     done, acc, carry, zero);
            miscompares++;
        end
        issue(LDB, 8'h00);
        vectors++;
        if (carry !== 1'b1) begin
            $display("FAIL ldb_keeps_carry got %b required 1", carry);
            miscompares++;
        end
        issue(ADD, 8'h00);
        tick();
        vectors++;
        if ({done, acc, carry, zero} !== {1'b1, 8'h10, 1'b0, 1'b0}) begin
            $display("FAIL add_b0 d/acc/c/z got %b %h %b %b required 1 10 0 0",
                     done, acc, carry, zero);
            miscompares++;
        end
    endtask

    task automatic test_sub();
        issue(LDA, 8'h05);
        issue(LDB, 8'h07);
        op_valid = 1'b1;
        op       = SUB;
        tick();
        vectors++;
        if ({op_ready, done} !== 2'b00) begin
            $display("FAIL sub_busy1 r/d got %b%b required 00", op_ready, done);
            miscompares++;
        end
        tick();
        vectors++;
        if ({op_ready, done, acc} !== {1'b0, 1'b0, 8'h05}) begin
            $display("FAIL sub_busy2 r/d/acc got %b %b %h required 0 0 05",
                     op_ready, done, acc);
            miscompares++;
        end
        tick();
        op_valid = 1'b0;
        op       = NOP;
        vectors++;
        if ({done, acc, carry, zero} !== {1'b1, 8'hFE, 1'b0, 1'b0}) begin
            $display("FAIL sub_fe d/acc/c/z got %b %h %b %b required 1 fe 0 0",
                     done, acc, carry, zero);
            miscompares++;
        end
        tick();
        vectors++;
        if ({done, acc, op_ready} !== {1'b0, 8'hFE, 1'b1}) begin
            $display("FAIL sub_once d/acc/r got %b %h %b required 0 fe 1",
                     done, acc, op_ready);
            miscompares++;
        end

        issue(LDA, 8'h42);
        issue(LDB, 8'h42);
        issue(SUB, 8'h00);
        tick();
        tick();
        vectors++;
        if ({done, acc, carry, zero} !== {1'b1, 8'h00, 1'b1, 1'b1}) begin
            $display("FAIL sub_eq d/acc/c/z got %b %h %b %b required 1 00 1 1",
                     done, acc, carry, zero);
            miscompares++;
        end
        issue(LDB, 8'h00);
        issue(SUB, 8'h00);
        tick();
        tick();
        vectors++;
        if ({done, acc, carry, zero} !== {1'b1, 8'h00, 1'b1, 1'b1}) begin
            $display("FAIL sub_b0 d/acc/c/z got %b %h %b %b required 1 00 1 1",
                     done, acc, carry, zero);
            miscompares++;
        end
    endtask

    task automatic test_reset_mid();
        issue(LDA, 8'h80);
        issue(LDB, 8'h01);
        issue(SUB, 8'h00);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({acc, b_out, carry, zero, done} !==
            {8'h00, 8'h00, 1'b0, 1'b1, 1'b0}) begin
            $display("FAIL mid_rst acc/b/c/z/d got %h %h %b %b %b required 00 00 0 1 0",
                     acc, b_out, carry, zero, done);
            miscompares++;
        end
        tick();
        tick();
        #2;
        rst_n = 1'b1;
        tick();
        vectors++;
        if ({op_ready, done, acc} !== {1'b1, 1'b0, 8'h00}) begin
            $display("FAIL mid_rst_rel r/d/acc got %b %b %h required 1 0 00",
                     op_ready, done, acc);
            miscompares++;
        end
        tick();
        vectors++;
        if ({op_ready, done} !== 2'b10) begin
            $display("FAIL mid_rst_nodone r/d got %b%b required 10", op_ready, done);
            miscompares++;
        end
    endtask

    task automatic test_back_to_back();
        issue(LDA, 8'hFF);
        issue(LDB, 8'h01);
        issue(ADD, 8'h00);
        tick();
        issue(LDA, 8'h05);
        vectors++;
        if ({acc, carry, zero} !== {8'h05, 1'b1, 1'b0}) begin
            $display("FAIL b2b_setup acc/c/z got %h %b %b required 05 1 0",
                     acc, carry, zero);
            miscompares++;
        end
        op_valid = 1'b1;
        op       = LDA;
        din      = 8'h00;
        tick();
        vectors++;
        if ({done, acc, carry, zero} !== {1'b1, 8'h00, 1'b1, 1'b1}) begin
            $display("FAIL b2b_lda d/acc/c/z got %b %h %b %b required 1 00 1 1",
                     done, acc, carry, zero);
            miscompares++;
        end
        op  = RSV;
        din = 8'h55;
        tick();
        vectors++;
        if ({done, acc, b_out, carry, zero} !==
            {1'b1, 8'h00, 8'h01, 1'b1, 1'b1}) begin
            $display("FAIL b2b_rsv d/acc/b/c/z got %b %h %h %b %b required 1 00 01 1 1",
                     done, acc, b_out, carry, zero);
            miscompares++;
        end
        op = CLR;
        tick();
        op_valid = 1'b0;
        op       = NOP;
        vectors++;
        if ({done, acc, carry, zero} !== {1'b1, 8'h00, 1'b0, 1'b1}) begin
            $display("FAIL b2b_clr d/acc/c/z got %b %h %b %b required 1 00 0 1",
                     done, acc, carry, zero);
            miscompares++;
        end
        tick();
        vectors++;
        if (done !== 1'b0) begin
            $display("FAIL b2b_end done got %b required 0", done);
            miscompares++;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        op_valid    = 1'b0;
        op          = NOP;
        din         = 8'h00;
        rst_n       = 1'b1;
        #1;
        test_reset();
        test_add();
        test_sub();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
